// File: rtl/cfg_vpd_pkg.sv
// Shared definitions for the VPD capability access initiator: FSM states,
// sticky status bit positions and the fill value loaded on a read timeout.
package cfg_vpd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } vpd_state_e;

    localparam int STAT_TIMEOUT  = 0;
    localparam int STAT_UNIMPL   = 1;
    localparam int STAT_DROPPED  = 2;
    localparam int STAT_SPURIOUS = 3;

    localparam logic [31:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

endpackage

// File: rtl/cfg_vpd_initiator.sv
// VPD capability initiator: turns host address/flag writes into a held read or
// write request toward the VPD responder, with timeout and sticky error status.
module cfg_vpd_initiator
    import cfg_vpd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clock_afu,
    input  logic        reset_afu_n,
    input  logic        cap_vpd_addr_we,
    input  logic [15:0] cap_vpd_addr_wdata,
    input  logic        cap_vpd_data_we,
    input  logic [31:0] cap_vpd_data_wdata,
    output logic [15:0] cap_vpd_addr_rdata,
    output logic [31:0] cap_vpd_data_rdata,
    input  logic        cap_vpd_err_clear,
    output logic        vpd_busy,
    output logic [3:0]  vpd_status,
    output logic [14:0] cfg_vpd_addr,
    output logic        cfg_vpd_wren,
    output logic [31:0] cfg_vpd_wdata,
    output logic        cfg_vpd_rden,
    input  logic [31:0] vpd_cfg_rdata,
    input  logic        vpd_cfg_done,
    input  logic        vpd_err_unimplemented_addr
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    // Abort on the edge that would close the TIMEOUT_CYCLES-th request cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    vpd_state_e       state_r, state_s;
    logic             flag_r, flag_s;
    logic [14:0]      addr_r, addr_s;
    logic [31:0]      data_r, data_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       status_r, status_s, set_s;
    logic             rden_r, rden_s;
    logic             wren_r, wren_s;

    // Next-state, datapath and status update for the access FSM.
    always_comb begin
        state_s = state_r;
        flag_s  = flag_r;
        addr_s  = addr_r;
        data_s  = data_r;
        cnt_s   = cnt_r;
        rden_s  = rden_r;
        wren_s  = wren_r;
        set_s   = 4'b0000;

        case (state_r)
            ST_IDLE: begin
                cnt_s                = CNT_ZERO;
                rden_s               = 1'b0;
                wren_s               = 1'b0;
                set_s[STAT_SPURIOUS] = vpd_cfg_done;
                if (cap_vpd_data_we) begin
                    data_s = cap_vpd_data_wdata;
                end else begin
                    data_s = data_r;
                end
                if (cap_vpd_addr_we) begin
                    addr_s = cap_vpd_addr_wdata[14:0];
                    flag_s = cap_vpd_addr_wdata[15];
                    if (cap_vpd_addr_wdata[15]) begin
                        state_s = ST_WRITE;
                        wren_s  = 1'b1;
                    end else begin
                        state_s = ST_READ;
                        rden_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ, ST_WRITE: begin
                set_s[STAT_DROPPED] = cap_vpd_addr_we | cap_vpd_data_we;
                // A done on the timeout edge still counts as a normal completion.
                if (vpd_cfg_done) begin
                    state_s            = ST_IDLE;
                    rden_s             = 1'b0;
                    wren_s             = 1'b0;
                    flag_s             = (state_r == ST_READ);
                    set_s[STAT_UNIMPL] = vpd_err_unimplemented_addr;
                    if (state_r == ST_READ) begin
                        data_s = vpd_cfg_rdata;
                    end else begin
                        data_s = data_r;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s             = ST_IDLE;
                    rden_s              = 1'b0;
                    wren_s              = 1'b0;
                    flag_s              = (state_r == ST_READ);
                    set_s[STAT_TIMEOUT] = 1'b1;
                    if (state_r == ST_READ) begin
                        data_s = TIMEOUT_FILL;
                    end else begin
                        data_s = data_r;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                rden_s  = 1'b0;
                wren_s  = 1'b0;
                cnt_s   = CNT_ZERO;
            end
        endcase

        if (cap_vpd_err_clear) begin
            status_s = set_s;
        end else begin
            status_s = status_r | set_s;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock_afu) begin
        if (!reset_afu_n) begin
            state_r  <= ST_IDLE;
            flag_r   <= 1'b0;
            addr_r   <= 15'h0000;
            data_r   <= 32'h0000_0000;
            cnt_r    <= CNT_ZERO;
            status_r <= 4'b0000;
            rden_r   <= 1'b0;
            wren_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            flag_r   <= flag_s;
            addr_r   <= addr_s;
            data_r   <= data_s;
            cnt_r    <= cnt_s;
            status_r <= status_s;
            rden_r   <= rden_s;
            wren_r   <= wren_s;
        end
    end

    // Address and data only change in IDLE, so both are stable for an access.
    assign cfg_vpd_addr       = addr_r;
    assign cfg_vpd_wdata      = data_r;
    assign cfg_vpd_rden       = rden_r;
    assign cfg_vpd_wren       = wren_r;
    assign vpd_busy           = (state_r != ST_IDLE);
    assign vpd_status         = status_r;
    assign cap_vpd_addr_rdata = {flag_r, addr_r};
    assign cap_vpd_data_rdata = data_r;

endmodule

// File: tb/tb_cfg_vpd_initiator.sv
// Scoreboard bench for cfg_vpd_initiator: expected access results are queued
// when an access is launched and compared when the DUT drops busy.
module tb_cfg_vpd_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        addr_we;
    logic [15:0] addr_wdata;
    logic        data_we;
    logic [31:0] data_wdata;
    logic [15:0] addr_rdata;
    logic [31:0] data_rdata;
    logic        err_clear;
    logic        busy;
    logic [3:0]  status;
    logic [14:0] cfg_addr;
    logic        wren;
    logic [31:0] wdata;
    logic        rden;
    logic [31:0] rdata;
    logic        done;
    logic        unimpl;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic [15:0] addr_rb;
        logic [31:0] data_rb;
        int          cycles;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_data;

    cfg_vpd_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clock_afu                  (clk),
        .reset_afu_n                (rst_n),
        .cap_vpd_addr_we            (addr_we),
        .cap_vpd_addr_wdata         (addr_wdata),
        .cap_vpd_data_we            (data_we),
        .cap_vpd_data_wdata         (data_wdata),
        .cap_vpd_addr_rdata         (addr_rdata),
        .cap_vpd_data_rdata         (data_rdata),
        .cap_vpd_err_clear          (err_clear),
        .vpd_busy                   (busy),
        .vpd_status                 (status),
        .cfg_vpd_addr               (cfg_addr),
        .cfg_vpd_wren               (wren),
        .cfg_vpd_wdata              (wdata),
        .cfg_vpd_rden               (rden),
        .vpd_cfg_rdata              (rdata),
        .vpd_cfg_done               (done),
        .vpd_err_unimplemented_addr (unimpl)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic data_write(input logic [31:0] d);
        data_we = 1'b1; data_wdata = d;
        step(1);
        data_we = 1'b0;
        model_data = d;
    endtask

    // lat = 0 means the responder never answers; drop_at pulses host writes on that cycle.
    task automatic access(input logic [15:0] aw, input int lat, input logic [31:0] rd,
                          input logic ue, input int drop_at);
        exp_t e;
        int   span;
        e.wr      = aw[15];
        e.addr    = aw[14:0];
        e.wdata   = model_data;
        e.addr_rb = {~aw[15], aw[14:0]};
        if (!aw[15]) model_data = (lat == 0) ? 32'hFFFF_FFFF : rd;
        e.data_rb = model_data;
        e.cycles  = (lat == 0) ? 16 : lat;
        sb_q.push_back(e);
        span = (lat == 0) ? 20 : lat;
        addr_we = 1'b1; addr_wdata = aw;
        step(1);
        addr_we = 1'b0;
        for (int c = 1; c <= span; c++) begin
            if (c == lat) begin
                done = 1'b1; rdata = rd; unimpl = ue;
            end
            if (c == drop_at) begin
                addr_we = 1'b1; addr_wdata = 16'h8001;
                data_we = 1'b1; data_wdata = 32'h1111_1111;
            end
            step(1);
            done = 1'b0; unimpl = 1'b0; addr_we = 1'b0; data_we = 1'b0;
        end
    endtask

    // Monitor: checks request integrity each cycle and retires expectations on busy fall.
    initial begin
        int   req_cycles;
        logic prev_busy;
        exp_t e;
        req_cycles = 0;
        prev_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (rden === 1'b1 || wren === 1'b1) begin
                req_cycles++;
                check_eq("req_excl", {31'b0, rden & wren}, 32'h0);
                if (sb_q.size() > 0) begin
                    check_eq("req_kind", {31'b0, wren}, {31'b0, sb_q[0].wr});
                    check_eq("req_addr", {17'b0, cfg_addr}, {17'b0, sb_q[0].addr});
                    if (sb_q[0].wr) check_eq("req_wdata", wdata, sb_q[0].wdata);
                end else begin
                    check_eq("sb_depth", sb_q.size(), 32'd1);
                end
            end
            if (prev_busy === 1'b1 && busy === 1'b0) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", sb_q.size(), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("addr_rb", {16'b0, addr_rdata}, {16'b0, e.addr_rb});
                    check_eq("data_rb", data_rdata, e.data_rb);
                    check_eq("req_cycles", req_cycles, e.cycles);
                end
                req_cycles = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; addr_we = 1'b0; addr_wdata = 16'h0; data_we = 1'b0;
        data_wdata = 32'h0; err_clear = 1'b0; rdata = 32'h0; done = 1'b0; unimpl = 1'b0;
        model_data = 32'h0;
        step(3);
        check_eq("rst_addr_rb", {16'b0, addr_rdata}, 32'h0);
        check_eq("rst_data_rb", data_rdata, 32'h0);
        check_eq("rst_busy", {31'b0, busy}, 32'h0);
        check_eq("rst_status", {28'b0, status}, 32'h0);
        check_eq("rst_rw", {30'b0, rden, wren}, 32'h0);
        check_eq("rst_cfg_addr", {17'b0, cfg_addr}, 32'h0);
        check_eq("rst_wdata", wdata, 32'h0);
        rst_n = 1'b1;
        step(1);

        access(16'h0123, 5, 32'hDEAD_BEEF, 1'b0, 0);
        step(1);
        check_eq("read_busy", {31'b0, busy}, 32'h0);
        check_eq("read_status", {28'b0, status}, 32'h0);

        data_write(32'hCAFE_F00D);
        check_eq("data_we_idle", data_rdata, 32'hCAFE_F00D);
        check_eq("data_we_nostart", {31'b0, busy}, 32'h0);
        access(16'h8042, 4, 32'h0, 1'b0, 0);
        step(1);

        access(16'h0055, 0, 32'h0, 1'b0, 0);
        step(1);
        check_eq("timeout_status", {28'b0, status}, 32'h1);
        err_clear = 1'b1; step(1); err_clear = 1'b0;
        check_eq("clear_status", {28'b0, status}, 32'h0);

        data_write(32'h1234_5678);
        access(16'h0077, 6, 32'h0BAD_0077, 1'b0, 2);
        step(1);
        check_eq("drop_status", {28'b0, status}, 32'h4);
        err_clear = 1'b1; step(1); err_clear = 1'b0;
        check_eq("clear2_status", {28'b0, status}, 32'h0);

        access(16'h0010, 3, 32'hA5A5_0010, 1'b0, 3);
        step(1);
        check_eq("done_we_status", {28'b0, status}, 32'h4);
        check_eq("done_we_idle", {31'b0, busy}, 32'h0);
        err_clear = 1'b1; step(1); err_clear = 1'b0;

        access(16'h8099, 2, 32'h0, 1'b1, 0);
        step(1);
        check_eq("unimpl_status", {28'b0, status}, 32'h2);
        done = 1'b1; step(1); done = 1'b0;
        check_eq("spurious_status", {28'b0, status}, 32'hA);
        err_clear = 1'b1; done = 1'b1; step(1); err_clear = 1'b0; done = 1'b0;
        check_eq("clear_vs_set", {28'b0, status}, 32'h8);

        data_write(32'h5555_AAAA);
        e.wr = 1'b1; e.addr = 15'h033; e.wdata = 32'h5555_AAAA;
        e.addr_rb = 16'h0000; e.data_rb = 32'h0; e.cycles = 4;
        sb_q.push_back(e);
        addr_we = 1'b1; addr_wdata = 16'h8033;
        step(1);
        addr_we = 1'b0;
        step(3);
        rst_n = 1'b0;
        step(1);
        check_eq("mid_rst_rw", {30'b0, rden, wren}, 32'h0);
        check_eq("mid_rst_busy", {31'b0, busy}, 32'h0);
        check_eq("mid_rst_status", {28'b0, status}, 32'h0);
        check_eq("mid_rst_cfg_addr", {17'b0, cfg_addr}, 32'h0);
        check_eq("mid_rst_wdata", wdata, 32'h0);
        rst_n = 1'b1;
        step(1);
        done = 1'b1; step(1); done = 1'b0;
        check_eq("late_done_status", {28'b0, status}, 32'h8);
        check_eq("late_done_idle", {31'b0, busy}, 32'h0);

        step(2);
        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
